// File: rtl/fft_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fft_stage_ctrl
//  Description : Sequencing controller for one radix-2 FFT stage. Aligns
//                incoming blocks to frames of 2^CLK_CNT blocks, pulses the
//                twiddle multiplier's block-counter enable, carries valid/SOF/
//                EOF tags alongside the fixed-latency datapath and turns
//                downstream backpressure into a global pipeline enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_stage_ctrl #(
    parameter int CLK_CNT  = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic               in_ready,
    output logic               twd10_valid,
    output logic [CLK_CNT-1:0] blk_idx,
    output logic               pipe_en,
    output logic               out_valid,
    output logic               out_sof,
    output logic               out_eof,
    input  logic               out_ready,
    output logic               frame_done,
    output logic               err_sof,
    output logic               err_drop,
    output logic [15:0]        frames_out
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Index of the final block of a frame; the beat accepted here carries EOF.
    localparam logic [CLK_CNT-1:0] c_blk_last = '1;

    state_t                r_state_q;
    state_t                w_state_d;
    logic [CLK_CNT-1:0]    r_blk_idx_q;
    logic [CLK_CNT-1:0]    w_blk_idx_d;
    logic [PIPE_LAT-1:0]   r_vld_sr_q;
    logic [PIPE_LAT-1:0]   w_vld_sr_d;
    logic [PIPE_LAT-1:0]   r_sof_sr_q;
    logic [PIPE_LAT-1:0]   w_sof_sr_d;
    logic [PIPE_LAT-1:0]   r_eof_sr_q;
    logic [PIPE_LAT-1:0]   w_eof_sr_d;
    logic [15:0]           r_frames_out_q;
    logic [15:0]           w_frames_out_d;

    logic                  w_pipe_en;
    logic                  w_accept;
    logic                  w_fwd;
    logic                  w_fwd_sof;
    logic                  w_fwd_eof;
    logic                  w_err_sof;
    logic                  w_err_drop;
    logic                  w_out_valid;
    logic                  w_frame_done;

    // Pipeline moves whenever the last stage is empty or is being delivered.
    assign w_pipe_en    = out_ready | ~r_vld_sr_q[PIPE_LAT-1];
    assign w_accept     = in_valid & w_pipe_en;
    assign w_out_valid  = r_vld_sr_q[PIPE_LAT-1];
    assign w_frame_done = w_out_valid & out_ready & r_eof_sr_q[PIPE_LAT-1];

    // Frame alignment: decide per accepted beat whether to forward or drop it.
    always_comb begin
        w_state_d   = r_state_q;
        w_blk_idx_d = r_blk_idx_q;
        w_fwd       = 1'b0;
        w_fwd_sof   = 1'b0;
        w_fwd_eof   = 1'b0;
        w_err_sof   = 1'b0;
        w_err_drop  = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (in_sof) begin
                        w_fwd     = 1'b1;
                        w_fwd_sof = 1'b1;
                        // A single-block frame closes immediately.
                        w_state_d = (r_blk_idx_q == c_blk_last) ? ST_IDLE : ST_RUN;
                    end else begin
                        w_err_drop = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (in_sof) begin
                        // Dropping a stray SOF keeps the multiplier counter
                        // parity in step with the forwarded-block count.
                        w_err_sof = 1'b1;
                    end else begin
                        w_fwd = 1'b1;
                        if (r_blk_idx_q == c_blk_last) begin
                            w_state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
        if (w_fwd) begin
            w_fwd_eof   = (r_blk_idx_q == c_blk_last);
            w_blk_idx_d = r_blk_idx_q + 1'b1;
        end
    end

    // Tag shift register: a dropped or absent beat enters stage 0 as a bubble.
    always_comb begin
        w_vld_sr_d = r_vld_sr_q;
        w_sof_sr_d = r_sof_sr_q;
        w_eof_sr_d = r_eof_sr_q;
        if (w_pipe_en) begin
            w_vld_sr_d[0] = w_fwd;
            w_sof_sr_d[0] = w_fwd_sof;
            w_eof_sr_d[0] = w_fwd_eof;
            for (int i = 1; i < PIPE_LAT; i++) begin
                w_vld_sr_d[i] = r_vld_sr_q[i-1];
                w_sof_sr_d[i] = r_sof_sr_q[i-1];
                w_eof_sr_d[i] = r_eof_sr_q[i-1];
            end
        end
        w_frames_out_d = r_frames_out_q + {15'd0, w_frame_done};
    end

    // State update with synchronous reset; in-flight tags are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_blk_idx_q    <= '0;
            r_vld_sr_q     <= '0;
            r_sof_sr_q     <= '0;
            r_eof_sr_q     <= '0;
            r_frames_out_q <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_blk_idx_q    <= w_blk_idx_d;
            r_vld_sr_q     <= w_vld_sr_d;
            r_sof_sr_q     <= w_sof_sr_d;
            r_eof_sr_q     <= w_eof_sr_d;
            r_frames_out_q <= w_frames_out_d;
        end
    end

    assign in_ready    = w_pipe_en;
    assign pipe_en     = w_pipe_en;
    assign twd10_valid = w_fwd;
    assign err_sof     = w_err_sof;
    assign err_drop    = w_err_drop;
    assign blk_idx     = r_blk_idx_q;
    assign out_valid   = w_out_valid;
    assign out_sof     = w_out_valid & r_sof_sr_q[PIPE_LAT-1];
    assign out_eof     = w_out_valid & r_eof_sr_q[PIPE_LAT-1];
    assign frame_done  = w_frame_done;
    assign frames_out  = r_frames_out_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_stage_ctrl
//  Description : Self-checking bench for fft_stage_ctrl. The driver issues
//                directed beats and queues the expected output tags; an
//                independent monitor pops and compares on every delivery.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_stage_ctrl;

    localparam int c_CLK_CNT  = 4;
    localparam int c_PIPE_LAT = 2;
    localparam int c_NBLK     = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        twd10_valid;
    logic [3:0]  blk_idx;
    logic        pipe_en;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic        frame_done;
    logic        err_sof;
    logic        err_drop;
    logic [15:0] frames_out;

    typedef struct packed {
        logic sof;
        logic eof;
    } tag_t;

    tag_t exp_q[$];
    tag_t mon_t;
    int   errors = 0;
    int   checks = 0;

    fft_stage_ctrl #(
        .CLK_CNT  (c_CLK_CNT),
        .PIPE_LAT (c_PIPE_LAT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .twd10_valid (twd10_valid),
        .blk_idx     (blk_idx),
        .pipe_en     (pipe_en),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .out_ready   (out_ready),
        .frame_done  (frame_done),
        .err_sof     (err_sof),
        .err_drop    (err_drop),
        .frames_out  (frames_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus with out_ready high; checks combinational outputs
    // and queues the expected tags of a forwarded beat.
    task automatic beat(input logic v, input logic s, input logic e_twd,
                        input logic e_es, input logic e_ed, input int e_blk,
                        input logic e_sof, input logic e_eof);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sof    = s;
        out_ready = 1'b1;
        #1;
        chk("in_ready", in_ready, 1);
        chk("twd10_valid", twd10_valid, e_twd);
        chk("err_sof", err_sof, e_es);
        chk("err_drop", err_drop, e_ed);
        chk("blk_idx", blk_idx, e_blk);
        if (e_twd) exp_q.push_back('{sof: e_sof, eof: e_eof});
    endtask

    task automatic send_frame();
        for (int i = 0; i < c_NBLK; i++)
            beat(1'b1, (i == 0), 1'b1, 1'b0, 1'b0, i, (i == 0), (i == c_NBLK - 1));
    endtask

    task automatic drain(input int exp_frames);
        for (int i = 0; i < 4; i++) beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("frames_out", frames_out, exp_frames);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sof", out_sof, 0);
        chk("rst_out_eof", out_eof, 0);
        chk("rst_blk_idx", blk_idx, 0);
        chk("rst_frames_out", frames_out, 0);
        chk("rst_pipe_en", pipe_en, 1);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_twd10_valid", twd10_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_sof", err_sof, 0);
        chk("rst_err_drop", err_drop, 0);
    endtask

    // Monitor: compare each delivered block against the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery: got out_valid=1 expected no block at %0t", $time);
                end else begin
                    mon_t = exp_q.pop_front();
                    chk("out_sof", out_sof, mon_t.sof);
                    chk("out_eof", out_eof, mon_t.eof);
                    chk("frame_done", frame_done, mon_t.eof);
                end
            end else begin
                chk("frame_done_idle", frame_done, 0);
                if (!out_valid) begin
                    chk("out_sof_gated", out_sof, 0);
                    chk("out_eof_gated", out_eof, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_state();

        // Single frame with latency check on the first block
        for (int i = 0; i < c_NBLK; i++) begin
            beat(1'b1, (i == 0), 1'b1, 1'b0, 1'b0, i, (i == 0), (i == c_NBLK - 1));
            if (i == 1) chk("latency_not_yet", out_valid, 0);
            if (i == 2) begin
                chk("latency_out_valid", out_valid, 1);
                chk("latency_out_sof", out_sof, 1);
            end
        end
        drain(1);

        // Two back-to-back frames, SOF right after EOF
        send_frame();
        send_frame();
        drain(3);

        // Stray SOF at block 7 is dropped; frame still ends on the 16th forward
        for (int i = 0; i < 7; i++)
            beat(1'b1, (i == 0), 1'b1, 1'b0, 1'b0, i, (i == 0), 1'b0);
        beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7, 1'b0, 1'b0);
        for (int i = 7; i < c_NBLK; i++)
            beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, i, 1'b0, (i == c_NBLK - 1));
        drain(4);

        // Non-SOF beats in IDLE are consumed and flagged
        for (int i = 0; i < 3; i++)
            beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        drain(4);

        // Backpressure while the SOF block sits at the output
        beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b1;
            in_sof    = 1'b0;
            out_ready = 1'b0;
            #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_pipe_en", pipe_en, 0);
            chk("stall_twd10_valid", twd10_valid, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_sof", out_sof, 1);
            chk("stall_out_eof", out_eof, 0);
            chk("stall_blk_idx", blk_idx, 2);
        end
        for (int i = 2; i < c_NBLK; i++)
            beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, i, 1'b0, (i == c_NBLK - 1));
        drain(5);

        // Reset mid-frame at block 9, then a clean frame
        for (int i = 0; i < 9; i++)
            beat(1'b1, (i == 0), 1'b1, 1'b0, 1'b0, i, (i == 0), 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_state();
        send_frame();
        drain(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_stage_ctrl.md
# fft_stage_ctrl

Sequencing controller for one radix-2 FFT stage: 16-lane butterfly followed by the twiddle multiplier. It accepts block-valid beats from upstream with a valid/ready handshake and enforces frame alignment of exactly 2^CLK_CNT blocks. It drives the `twd10_valid` pulse that advances the multiplier's internal block counter, and tags and tracks blocks through the fixed-latency datapath, applying output backpressure as a global pipeline enable. It sits between the stage's input buffer and the next stage, and owns no sample data.

## Interface
- `CLK_CNT`, default 4: log2 of blocks per frame. Must match the twiddle multiplier's `CLK_CNT`.
- `PIPE_LAT`, default 2: register stages in the butterfly plus twiddle datapath. Range 1..8.
- `clk` in, 1 bit: clock. One clock only.
- `rst` in, 1 bit: reset, synchronous and active-high. Top ties datapath `rstn = ~rst`, so the multiplier counter clears with this block.
- `in_valid` in, 1 bit: upstream block valid.
- `in_sof` in, 1 bit: first block of a frame; qualified by `in_valid`.
- `in_ready` out, 1 bit: combinational; block accepted when `in_valid & in_ready`.
- `twd10_valid` out, 1 bit: one-cycle pulse per forwarded block, to the multiplier counter enable.
- `blk_idx` out, CLK_CNT bits: index of the block currently being accepted.
- `pipe_en` out, 1 bit: global enable for all datapath pipeline registers.
- `out_valid` out, 1 bit: output block valid.
- `out_sof` out, 1 bit: output first-block tag.
- `out_eof` out, 1 bit: output last-block tag.
- `out_ready` in, 1 bit: downstream ready.
- `frame_done` out, 1 bit: pulse when an EOF block is delivered.
- `err_sof` out, 1 bit: pulse when an SOF beat is dropped mid-frame.
- `err_drop` out, 1 bit: pulse when a non-SOF beat is dropped in IDLE.
- `frames_out` out, 16 bits: delivered-frame counter. Wraps.

## Operation
- FSM has two states: IDLE and RUN. Reset state is IDLE.
- Pipeline enable: `pipe_en = out_ready | ~vld_sr[PIPE_LAT-1]`. `in_ready = pipe_en` in both states.
- IDLE, accepted beat with `in_sof=1`:
  - forward the beat: assert `twd10_valid`;
  - `blk_idx` 0 goes to 1;
  - go to RUN.
- IDLE, accepted beat with `in_sof=0`: consume the beat without forwarding it. `twd10_valid=0`, `err_drop` pulses, `blk_idx` holds.
- RUN, accepted beat with `in_sof=0`: forward the beat and increment `blk_idx`.
  - At `blk_idx = 2^CLK_CNT-1` the beat is tagged EOF.
  - `blk_idx` wraps to 0 and the FSM returns to IDLE.
- RUN, accepted beat with `in_sof=1`: drop the beat. `err_sof` pulses, no `twd10_valid`, state and `blk_idx` unchanged.
  - This keeps the multiplier counter aligned: its LSB always equals forwarded-block parity.
- Tag pipeline:
  - valid, sof and eof travel through a PIPE_LAT-deep shift register `vld_sr/sof_sr/eof_sr`.
  - The register advances only when `pipe_en=1`.
  - The stage-0 inputs are the forwarded-beat valid and its tags.
- Outputs are taken from the last stage: `out_valid = vld_sr[PIPE_LAT-1]`, with `out_sof` and `out_eof` from the same stage.
  - The tags are gated by `out_valid`, so they read 0 when `out_valid=0`.
- Delivery is `out_valid & out_ready`. On delivery of an EOF block:
  - `frame_done` pulses in the same cycle (combinational);
  - `frames_out` increments on the next edge.
- Dropped beats still consume a `pipe_en` cycle: a bubble enters stage 0.

## Timing
- Reset values:
  - FSM IDLE, `blk_idx=0`;
  - all shift registers 0, so `out_valid`, `out_sof` and `out_eof` are 0;
  - `frames_out=0`;
  - `twd10_valid`, `err_sof`, `err_drop` and `frame_done` are 0;
  - `pipe_en=1` and `in_ready=1` in the first cycle after reset.
- Latency: a block accepted at edge N appears with `out_valid=1` after edge N+PIPE_LAT when `out_ready` stays high.
- Throughput: 1 block per cycle with no bubbles between frames. SOF is accepted in the same cycle IDLE is re-entered, so EOF at N and SOF at N+1 is legal.
- `twd10_valid`, `err_*` and `in_ready` are combinational from `in_valid`, `in_sof`, state and `out_ready`. All state updates happen on the rising edge.
- Backpressure:
  - `out_ready=0` with `out_valid=1` forces `pipe_en=0` and `in_ready=0`;
  - all tag stages hold and `out_valid` stays stable until delivery;
  - bubbles in the pipeline still collapse, because `pipe_en=1` whenever the last stage is empty.
- `rst` mid-frame clears everything in one cycle. Blocks in flight are lost and the multiplier counter clears via the tied reset.
- `frames_out` wraps from 0xFFFF to 0.

## Test plan
- Reset, then 16 consecutive beats (SOF on the first) with `out_ready=1`, PIPE_LAT=2:
  - `twd10_valid` high for 16 cycles, `blk_idx` 0..15;
  - `out_sof` at cycle 2, `out_eof` at cycle 17;
  - `frame_done` once, `frames_out=1`.
- Two back-to-back frames (32 beats): zero bubbles, `frames_out=2`, and `blk_idx` wraps 15 to 0 with SOF accepted the next cycle.
- SOF injected at block 7 mid-frame:
  - `err_sof` pulses once and that beat is not forwarded;
  - the frame still ends at the 16th forwarded beat, with EOF on `blk_idx=15`.
- IDLE, 3 beats without SOF: `err_drop` pulses 3 times, `twd10_valid` stays 0 and `blk_idx` stays 0.
- `out_ready` low for 5 cycles mid-frame:
  - outputs hold stable and `in_ready=0` throughout;
  - after release, ordering and count are unchanged (16 delivered, one EOF).
- `rst` asserted at block 9:
  - all outputs return to reset values next cycle;
  - the following SOF frame completes normally with `frames_out=1`.
